// File: rtl/mempipe_ctrl_pkg.sv
// Shared types and constants for the memory-pipeline controller.
//
// Contents:
//   - Requester index constants (STQ, LDQ, fill buffer) and default sizes.
//   - t_nuke_pkt        : flush broadcast; the controller uses only .valid.
//   - t_mempipe_arb     : the packet a requester hands to the pipe at mm0.
//   - t_mempipe_action  : what mm5 tells the requester to do with its op.
//   - t_mempipe_stage   : one pipe stage (valid bit + packet).
//   - find_first        : one-hot of the lowest set bit of a vector.
package mempipe_ctrl_pkg;

    localparam int MEMPIPE_REQ_STQ      = 0;
    localparam int MEMPIPE_REQ_LDQ      = 1;
    localparam int MEMPIPE_REQ_FB       = 2;
    localparam int MEMPIPE_NREQS        = 3;
    localparam int MEMPIPE_STARVE_LIMIT = 8;

    // Widest requester vector find_first handles; NREQS must not exceed it.
    localparam int MEMPIPE_MAX_REQS     = 8;

    typedef struct packed {
        logic       valid;
        logic [5:0] rob_id;
    } t_nuke_pkt;

    typedef struct packed {
        logic [1:0]  src;
        logic        is_store;
        logic [14:0] addr;
        logic [3:0]  id;
    } t_mempipe_arb;

    typedef struct packed {
        logic complete;
        logic recycle;
    } t_mempipe_action;

    typedef struct packed {
        logic         valid;
        t_mempipe_arb pkt;
    } t_mempipe_stage;

    // Two's-complement trick: vec & -vec isolates the lowest set bit.
    function automatic logic [MEMPIPE_MAX_REQS-1:0] find_first(
        input logic [MEMPIPE_MAX_REQS-1:0] vec
    );
        return vec & (~vec + MEMPIPE_MAX_REQS'(1));
    endfunction

endpackage

// File: rtl/mempipe_ctrl_starve_arb.sv
// mempipe_starve_arb: fixed-priority arbiter with per-requester starvation
// counters.
//
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   req [NREQS] : per-requester request
//   block       : suppresses every grant this cycle
//   gnt [NREQS] : one-hot grant, combinational from req/block/counters
//
// Lowest index wins normally. A requester denied for STARVE_LIMIT
// consecutive requesting cycles (blocked cycles included) becomes starved;
// the lowest-index starved requester then beats everyone else.
module mempipe_starve_arb
    import mempipe_ctrl_pkg::*;
#(
    parameter int NREQS        = MEMPIPE_NREQS,
    parameter int STARVE_LIMIT = MEMPIPE_STARVE_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQS-1:0] req,
    input  logic             block,
    output logic [NREQS-1:0] gnt
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [NREQS-1:0][CNT_W-1:0]  cnt_q;
    logic [NREQS-1:0][CNT_W-1:0]  cnt_d;
    logic [NREQS-1:0]             starved;
    logic [MEMPIPE_MAX_REQS-1:0]  pick_vec;
    logic [MEMPIPE_MAX_REQS-1:0]  pick_onehot;
    logic                         unused_pick;

    // Bits above NREQS are always zero; fold them so nothing dangles.
    assign unused_pick = ^pick_onehot;

    always_comb begin
        starved     = '0;
        pick_vec    = '0;
        pick_onehot = '0;
        gnt         = '0;
        cnt_d       = cnt_q;

        // Only a requester that is still asking can win as starved.
        for (int i = 0; i < NREQS; i++) begin
            starved[i] = req[i] && (cnt_q[i] == CNT_MAX);
        end

        pick_vec[NREQS-1:0] = (|starved) ? starved : req;
        pick_onehot         = find_first(pick_vec);
        gnt                 = block ? '0 : pick_onehot[NREQS-1:0];

        for (int i = 0; i < NREQS; i++) begin
            if (!req[i] || gnt[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mempipe_ctrl.sv
// mempipe_ctrl: memory-pipeline front end and stage control.
//
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   nuke_rb1          : flush; .valid clears mm1..mm5 at the edge
//   req_mm0           : per-requester request (0=STQ, 1=LDQ, 2=FB)
//   req_pkt_mm0       : per-requester packet
//   gnt_mm0           : one-hot grant, combinational
//   block_mm0         : tag array busy, no grant this cycle
//   hit_mm4           : tag hit for the op currently in mm4
//   pipe_valid_mm5    : registered mm5 valid
//   pipe_req_pkt_mm5  : registered mm5 packet
//   pipe_action_mm5   : registered mm5 action (complete / recycle)
//   idle              : no valid op in mm1..mm5
//
// The pipe never stalls: every stage shifts every cycle, so a grant in
// cycle N is broadcast at mm5 in cycle N+5.
module mempipe_ctrl
    import mempipe_ctrl_pkg::*;
#(
    parameter int NREQS        = MEMPIPE_NREQS,
    parameter int STARVE_LIMIT = MEMPIPE_STARVE_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  t_nuke_pkt        nuke_rb1,
    input  logic [NREQS-1:0] req_mm0,
    input  t_mempipe_arb     req_pkt_mm0 [NREQS],
    output logic [NREQS-1:0] gnt_mm0,
    input  logic             block_mm0,
    input  logic             hit_mm4,
    output logic             pipe_valid_mm5,
    output t_mempipe_arb     pipe_req_pkt_mm5,
    output t_mempipe_action  pipe_action_mm5,
    output logic             idle
);

    t_mempipe_stage [5:1] stage_q;
    t_mempipe_stage [5:1] stage_d;
    t_mempipe_action      action_q;
    t_mempipe_action      action_d;
    t_mempipe_arb         gnt_pkt;
    logic                 unused_nuke;

    assign unused_nuke = ^nuke_rb1.rob_id;

    mempipe_starve_arb #(
        .NREQS        (NREQS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_mm0),
        .block (block_mm0),
        .gnt   (gnt_mm0)
    );

    always_comb begin
        gnt_pkt  = '0;
        stage_d  = '0;
        action_d = '0;

        for (int i = 0; i < NREQS; i++) begin
            if (gnt_mm0[i]) begin
                gnt_pkt = req_pkt_mm0[i];
            end
        end

        // A grant in a nuke cycle is still visible to the requester but is
        // not allowed into mm1.
        stage_d[1].valid = (|gnt_mm0) && !nuke_rb1.valid;
        stage_d[1].pkt   = gnt_pkt;
        for (int s = 2; s <= 5; s++) begin
            stage_d[s].valid = stage_q[s-1].valid && !nuke_rb1.valid;
            stage_d[s].pkt   = stage_q[s-1].pkt;
        end

        action_d.complete = stage_d[5].valid && hit_mm4;
        action_d.recycle  = stage_d[5].valid && !hit_mm4;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q  <= '0;
            action_q <= '0;
        end else begin
            stage_q  <= stage_d;
            action_q <= action_d;
        end
    end

    assign pipe_valid_mm5   = stage_q[5].valid;
    assign pipe_req_pkt_mm5 = stage_q[5].pkt;
    assign pipe_action_mm5  = action_q;
    assign idle             = ~(stage_q[1].valid | stage_q[2].valid | stage_q[3].valid |
                                stage_q[4].valid | stage_q[5].valid);

endmodule

// File: tb/tb_mempipe_ctrl.sv
// Directed bench for mempipe_ctrl: reset state, single op latency/action,
// fixed priority, starvation (request-driven and block-driven), nuke,
// grant-in-nuke-cycle drop, and asynchronous reset with ops in flight.
module tb_mempipe_ctrl;
    import mempipe_ctrl_pkg::*;

    localparam int NREQS        = 3;
    localparam int STARVE_LIMIT = 8;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             reset;
    t_nuke_pkt        nuke_rb1;
    logic [NREQS-1:0] req_mm0;
    t_mempipe_arb     req_pkt_mm0 [NREQS];
    logic [NREQS-1:0] gnt_mm0;
    logic             block_mm0;
    logic             hit_mm4;
    logic             pipe_valid_mm5;
    t_mempipe_arb     pipe_req_pkt_mm5;
    t_mempipe_action  pipe_action_mm5;
    logic             idle;

    always #5 clk = ~clk;

    mempipe_ctrl #(
        .NREQS        (NREQS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .nuke_rb1         (nuke_rb1),
        .req_mm0          (req_mm0),
        .req_pkt_mm0      (req_pkt_mm0),
        .gnt_mm0          (gnt_mm0),
        .block_mm0        (block_mm0),
        .hit_mm4          (hit_mm4),
        .pipe_valid_mm5   (pipe_valid_mm5),
        .pipe_req_pkt_mm5 (pipe_req_pkt_mm5),
        .pipe_action_mm5  (pipe_action_mm5),
        .idle             (idle)
    );

    // ---------------- scoreboard ----------------
    int           n_vec = 0;
    int           n_err = 0;
    logic [31:0]  exp_q[$];
    t_mempipe_arb pkt_base [NREQS];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Compare the mm5 broadcast against the oldest expected packet.
    task automatic check_mm5(input string tag, input logic [1:0] exp_action);
        logic [31:0] exp_pkt;
        check({tag, "_valid"}, 32'(pipe_valid_mm5), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(pipe_req_pkt_mm5), 32'hffff_ffff);
        end else begin
            exp_pkt = exp_q.pop_front();
            check({tag, "_pkt"}, 32'(pipe_req_pkt_mm5), exp_pkt);
        end
        check({tag, "_action"}, 32'(pipe_action_mm5), 32'(exp_action));
    endtask

    // ---------------- driver tasks ----------------
    function automatic t_mempipe_arb mk_pkt(input logic [1:0] src, input logic st,
                                            input logic [14:0] addr, input logic [3:0] id);
        t_mempipe_arb p;
        p.src      = src;
        p.is_store = st;
        p.addr     = addr;
        p.id       = id;
        return p;
    endfunction

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drain();
        req_mm0   = '0;
        block_mm0 = 1'b0;
        hit_mm4   = 1'b0;
        nuke_rb1  = '0;
        repeat (6) next_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        pkt_base[0] = mk_pkt(2'd0, 1'b1, 15'h1000, 4'h1);
        pkt_base[1] = mk_pkt(2'd1, 1'b0, 15'h2004, 4'h2);
        pkt_base[2] = mk_pkt(2'd2, 1'b0, 15'h3008, 4'h3);
        for (int i = 0; i < NREQS; i++) req_pkt_mm0[i] = pkt_base[i];
        reset     = 1'b0;
        nuke_rb1  = '0;
        req_mm0   = '0;
        block_mm0 = 1'b0;
        hit_mm4   = 1'b0;

        // Reset state; grant stays combinational during reset.
        #2;
        check("rst_valid",  32'(pipe_valid_mm5),   32'd0);
        check("rst_pkt",    32'(pipe_req_pkt_mm5), 32'd0);
        check("rst_action", 32'(pipe_action_mm5),  32'd0);
        check("rst_idle",   32'(idle),             32'd1);
        req_mm0 = 3'b100;
        settle();
        check("rst_gnt_follows", 32'(gnt_mm0), 32'b100);
        req_mm0 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cnt_fb", 32'(dut.u_arb.cnt_q[2]), 32'd0);
        reset = 1'b1;

        // Single LDQ op with hit: grant at N, complete at N+5.
        next_cycle();
        req_mm0 = 3'b010;
        exp_q.push_back(32'(pkt_base[1]));
        settle();
        check("t1_gnt", 32'(gnt_mm0), 32'b010);
        next_cycle();
        req_mm0 = '0;
        settle();
        check("t1_busy", 32'(idle), 32'd0);
        repeat (3) next_cycle();
        hit_mm4 = 1'b1;
        settle();
        check("t1_n4_valid", 32'(pipe_valid_mm5), 32'd0);
        next_cycle();
        hit_mm4 = 1'b0;
        settle();
        check_mm5("t1_n5", 2'b10);
        next_cycle();
        settle();
        check("t1_n6_valid", 32'(pipe_valid_mm5), 32'd0);
        check("t1_n6_idle",  32'(idle),           32'd1);

        // Fixed priority: all three request for 3 cycles, STQ wins each time.
        exp_q.delete();
        exp_q.push_back(32'(pkt_base[0]));
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            req_mm0 = 3'b111;
            settle();
            check($sformatf("t2_gnt%0d", k), 32'(gnt_mm0), 32'b001);
        end
        next_cycle();
        req_mm0 = '0;
        settle();
        check("t2_cnt_stq", 32'(dut.u_arb.cnt_q[0]), 32'd0);
        check("t2_cnt_ldq", 32'(dut.u_arb.cnt_q[1]), 32'd3);
        check("t2_cnt_fb",  32'(dut.u_arb.cnt_q[2]), 32'd3);
        next_cycle();
        settle();
        check("t2_cnt_ldq_drop", 32'(dut.u_arb.cnt_q[1]), 32'd0);
        next_cycle();
        settle();
        check_mm5("t2_first_mm5", 2'b01);
        drain();

        // Starvation: LDQ denied 8 times, wins the 9th, STQ wins the 10th.
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            req_mm0 = 3'b011;
            settle();
            check($sformatf("t3_gnt_c%0d", k), 32'(gnt_mm0), 32'b001);
        end
        next_cycle();
        settle();
        check("t3_cnt_ldq_sat", 32'(dut.u_arb.cnt_q[1]), 32'd8);
        check("t3_gnt_c9",      32'(gnt_mm0),            32'b010);
        next_cycle();
        settle();
        check("t3_cnt_ldq_clr", 32'(dut.u_arb.cnt_q[1]), 32'd0);
        check("t3_cnt_stq",     32'(dut.u_arb.cnt_q[0]), 32'd1);
        check("t3_gnt_c10",     32'(gnt_mm0),            32'b001);
        drain();

        // Block: FB held off two cycles, granted on the third.
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            req_mm0   = 3'b100;
            block_mm0 = 1'b1;
            settle();
            check($sformatf("t4_gnt_blk%0d", k), 32'(gnt_mm0), 32'b000);
        end
        next_cycle();
        block_mm0 = 1'b0;
        settle();
        check("t4_cnt_fb", 32'(dut.u_arb.cnt_q[2]), 32'd2);
        check("t4_gnt_c3", 32'(gnt_mm0),            32'b100);
        next_cycle();
        req_mm0 = '0;
        settle();
        check("t4_cnt_fb_clr", 32'(dut.u_arb.cnt_q[2]), 32'd0);

        // Long block starves everyone; release resolves in index order.
        for (int k = 1; k <= 10; k++) begin
            next_cycle();
            req_mm0   = 3'b111;
            block_mm0 = 1'b1;
            settle();
            check($sformatf("t4b_gnt_blk%0d", k), 32'(gnt_mm0), 32'b000);
        end
        next_cycle();
        block_mm0 = 1'b0;
        settle();
        check("t4b_cnt_stq", 32'(dut.u_arb.cnt_q[0]), 32'd8);
        check("t4b_cnt_ldq", 32'(dut.u_arb.cnt_q[1]), 32'd8);
        check("t4b_cnt_fb",  32'(dut.u_arb.cnt_q[2]), 32'd8);
        check("t4b_gnt_r1",  32'(gnt_mm0),            32'b001);
        next_cycle();
        settle();
        check("t4b_gnt_r2", 32'(gnt_mm0), 32'b010);
        next_cycle();
        settle();
        check("t4b_gnt_r3", 32'(gnt_mm0), 32'b100);
        next_cycle();
        settle();
        check("t4b_gnt_r4", 32'(gnt_mm0), 32'b001);
        drain();

        // Nuke: four back-to-back LDQ grants; nuke in N+6 leaves only ops 1, 2.
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            req_mm0        = 3'b010;
            req_pkt_mm0[1] = mk_pkt(2'd1, 1'b0, 15'h0400 + 15'(k * 8), 4'(8 + k));
            exp_q.push_back(32'(req_pkt_mm0[1]));
            settle();
            check($sformatf("t5_gnt%0d", k), 32'(gnt_mm0), 32'b010);
        end
        next_cycle();
        req_mm0        = '0;
        req_pkt_mm0[1] = pkt_base[1];
        hit_mm4        = 1'b1;
        next_cycle();
        hit_mm4 = 1'b0;
        settle();
        check_mm5("t5_op1", 2'b10);
        next_cycle();
        nuke_rb1.valid = 1'b1;
        settle();
        check_mm5("t5_op2", 2'b01);
        exp_q.delete();
        next_cycle();
        nuke_rb1.valid = 1'b0;
        settle();
        check("t5_n7_valid", 32'(pipe_valid_mm5), 32'd0);
        check("t5_n7_idle",  32'(idle),           32'd1);
        next_cycle();
        settle();
        check("t5_n8_valid", 32'(pipe_valid_mm5), 32'd0);
        drain();

        // Grant in a nuke cycle is returned but never reaches mm1.
        next_cycle();
        req_mm0        = 3'b001;
        nuke_rb1.valid = 1'b1;
        settle();
        check("t6_gnt", 32'(gnt_mm0), 32'b001);
        next_cycle();
        req_mm0        = '0;
        nuke_rb1.valid = 1'b0;
        settle();
        check("t6_idle", 32'(idle), 32'd1);
        repeat (4) next_cycle();
        settle();
        check("t6_m5_valid", 32'(pipe_valid_mm5), 32'd0);
        drain();

        // Async reset with ops in flight.
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            req_mm0 = 3'b001;
            settle();
            check($sformatf("t7_gnt%0d", k), 32'(gnt_mm0), 32'b001);
        end
        next_cycle();
        req_mm0 = '0;
        next_cycle();
        settle();
        check("t7_pre_valid", 32'(pipe_valid_mm5), 32'd1);
        check("t7_pre_idle",  32'(idle),           32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("t7_rst_valid", 32'(pipe_valid_mm5), 32'd0);
        check("t7_rst_idle",  32'(idle),           32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        next_cycle();
        req_mm0 = 3'b100;
        exp_q.push_back(32'(pkt_base[2]));
        settle();
        check("t7_gnt_after", 32'(gnt_mm0), 32'b100);
        next_cycle();
        req_mm0 = '0;
        repeat (3) next_cycle();
        settle();
        check("t7_q4_valid", 32'(pipe_valid_mm5), 32'd0);
        next_cycle();
        settle();
        check_mm5("t7_q5", 2'b01);
        next_cycle();
        settle();
        check("t7_q6_idle", 32'(idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
